// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate controller: gate FSM state
// encoding, gate indices and default sizing constants.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OPEN_WAIT = 2'd1,
        PASSING   = 2'd2
    } gate_state_t;

    localparam int DEF_CAPACITY = 200;
    localparam int DEF_TIMEOUT  = 1000;

    // Gate slots in the per-gate vectors; bit order matches timeout_pulse.
    localparam int NUM_GATES  = 2;
    localparam int GATE_ENTRY = 0;
    localparam int GATE_EXIT  = 1;

endpackage

// File: rtl/parking_gate_ctrl_gate_fsm.sv
// One barrier gate: IDLE -> OPEN_WAIT -> PASSING -> IDLE with an open-wait
// timeout. commit_pulse marks the cycle whose clock edge completes a passage.
module gate_fsm
    import parking_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TW      = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic grant,
    input  logic pass,
    output logic gate_open,
    output logic commit_pulse,
    output logic timeout_pulse
);

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    gate_state_t   state, state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    // A pass on the final wait cycle takes priority over the timeout.
    assign tmo_hit = (state == OPEN_WAIT) && !pass && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (req && grant) state_nxt = OPEN_WAIT;
            OPEN_WAIT: begin
                if (pass)         state_nxt = PASSING;
                else if (tmo_hit) state_nxt = IDLE;
            end
            PASSING:   if (!pass) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gate_open    = (state != IDLE);
        commit_pulse = (state == PASSING) && !pass;
    end

    // Counter sits at zero in IDLE so every open starts a fresh wait.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                   tmo_cnt <= '0;
        else if (state == OPEN_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
        else                         tmo_cnt <= '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) timeout_pulse <= 1'b0;
        else       timeout_pulse <= tmo_hit;
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking lot gate controller: two gate FSMs, the occupancy register with
// merged entry/exit commits, full-lot entry refusal and underflow tracking.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int CW       = 8,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int TW       = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          entry_req,
    input  logic          entry_pass,
    input  logic          exit_req,
    input  logic          exit_pass,
    output logic          entry_gate_open,
    output logic          exit_gate_open,
    output logic [CW-1:0] occupancy,
    output logic          full,
    output logic          empty,
    output logic          deny_pulse,
    output logic [1:0]    timeout_pulse,
    output logic          underflow_err
);

    localparam logic [CW-1:0] CAP = CW'(CAPACITY);

    logic [NUM_GATES-1:0] req, pass, grant, gate_open, commit, tmo;
    logic                 deny_cond, deny_prev;

    assign req   = {exit_req,  entry_req};
    assign pass  = {exit_pass, entry_pass};
    // Exits are always admitted; entry is refused once the lot is full.
    assign grant = {1'b1, ~full};

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        gate_fsm #(
            .TIMEOUT (TIMEOUT),
            .TW      (TW)
        ) u_gate (
            .clock         (clock),
            .reset         (reset),
            .req           (req[g]),
            .grant         (grant[g]),
            .pass          (pass[g]),
            .gate_open     (gate_open[g]),
            .commit_pulse  (commit[g]),
            .timeout_pulse (tmo[g])
        );
    end

    assign entry_gate_open = gate_open[GATE_ENTRY];
    assign exit_gate_open  = gate_open[GATE_EXIT];
    assign timeout_pulse   = tmo;

    assign full  = (occupancy == CAP);
    assign empty = (occupancy == '0);

    // Simultaneous entry and exit commits cancel; a lone exit at zero saturates
    // and latches the error instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occupancy     <= '0;
            underflow_err <= 1'b0;
        end else begin
            case ({commit[GATE_EXIT], commit[GATE_ENTRY]})
                2'b01: occupancy <= occupancy + 1'b1;
                2'b10: begin
                    if (empty) underflow_err <= 1'b1;
                    else       occupancy     <= occupancy - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Refusal is reported once per held request, only while the gate is idle.
    assign deny_cond = !gate_open[GATE_ENTRY] && entry_req && full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deny_prev  <= 1'b0;
            deny_pulse <= 1'b0;
        end else begin
            deny_prev  <= deny_cond;
            deny_pulse <= deny_cond && !deny_prev;
        end
    end

endmodule
